// File: rtl/reg_file_scoreboard.sv
// Integer register file with two registered read ports, writeback forwarding, and a
// per-register pending-write scoreboard that flags RAW hazards and saturated counters.
module reg_file_scoreboard #(
  parameter int REG_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int PEND_WIDTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rf_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [REG_WIDTH-1:0]     rf_wr_val,
  input  logic                     rd1_en,
  input  logic [RF_ADDR_WIDTH-1:0] rd1_addr,
  output logic [REG_WIDTH-1:0]     rd1_val,
  input  logic                     rd2_en,
  input  logic [RF_ADDR_WIDTH-1:0] rd2_addr,
  output logic [REG_WIDTH-1:0]     rd2_val,
  input  logic                     iss_valid,
  input  logic                     iss_rd_en,
  input  logic [RF_ADDR_WIDTH-1:0] iss_rd_addr,
  output logic                     hazard,
  output logic                     pend_full
);

  localparam int NREGS = 2 ** RF_ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  typedef logic [RF_ADDR_WIDTH-1:0] addr_t;

  logic [REG_WIDTH-1:0]  regs [NREGS];
  logic [PEND_WIDTH-1:0] pend [NREGS];

  logic [NREGS-1:1]      inc_vec, dec_vec;
  logic [PEND_WIDTH-1:0] pend_rd1, pend_rd2, pend_iss, pend_wr;
  logic [REG_WIDTH-1:0]  rd1_next, rd2_next;
  logic                  inc_overflow, dec_underflow;

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      inc_vec[i] = iss_valid && iss_rd_en && (iss_rd_addr == addr_t'(i));
      dec_vec[i] = rf_wr_en && (rf_wr_addr == addr_t'(i));
    end
  end

  always_comb begin
    pend_rd1 = pend[rd1_addr];
    pend_rd2 = pend[rd2_addr];
    pend_iss = pend[iss_rd_addr];
    pend_wr  = pend[rf_wr_addr];

    // A read whose last outstanding write lands this cycle is served by the forward path.
    hazard = (rd1_en && rd1_addr != '0 && pend_rd1 != '0 &&
              !(rf_wr_en && rf_wr_addr == rd1_addr && pend_rd1 == PEND_ONE)) ||
             (rd2_en && rd2_addr != '0 && pend_rd2 != '0 &&
              !(rf_wr_en && rf_wr_addr == rd2_addr && pend_rd2 == PEND_ONE));

    pend_full = iss_rd_en && iss_rd_addr != '0 && pend_iss == PEND_MAX &&
                !(rf_wr_en && rf_wr_addr == iss_rd_addr);

    inc_overflow  = iss_valid && pend_full;
    dec_underflow = rf_wr_en && rf_wr_addr != '0 && pend_wr == '0 &&
                    !(iss_valid && iss_rd_en && iss_rd_addr == rf_wr_addr);
  end

  always_comb begin
    rd1_next = regs[rd1_addr];
    if (rf_wr_en && rf_wr_addr == rd1_addr) rd1_next = rf_wr_val;
    if (rd1_addr == '0) rd1_next = '0;

    rd2_next = regs[rd2_addr];
    if (rf_wr_en && rf_wr_addr == rd2_addr) rd2_next = rf_wr_val;
    if (rd2_addr == '0) rd2_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural state must read as zero after reset, so the whole array is cleared here.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      rd1_val <= '0;
      rd2_val <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so reads see pre-edge values.
      if (rf_wr_en && rf_wr_addr != '0) regs[rf_wr_addr] <= rf_wr_val;
      if (rd1_en) rd1_val <= rd1_next;
      if (rd2_en) rd2_val <= rd2_next;

      // Out-of-protocol increments at max or decrements at zero leave the counter untouched.
      for (int i = 1; i < NREGS; i++) begin
        if (inc_vec[i] && !dec_vec[i] && pend[i] != PEND_MAX)
          pend[i] <= pend[i] + PEND_ONE;
        else if (dec_vec[i] && !inc_vec[i] && pend[i] != '0)
          pend[i] <= pend[i] - PEND_ONE;
      end
    end
  end

  a_no_pend_overflow:  assert property (@(posedge clk) disable iff (rst) !inc_overflow);
  a_no_pend_underflow: assert property (@(posedge clk) disable iff (rst) !dec_underflow);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios with literal expectations, then
// constrained-random traffic checked every cycle against an array-based reference model.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_val;
  logic        rd1_en, rd2_en;
  logic [4:0]  rd1_addr, rd2_addr;
  logic [31:0] rd1_val, rd2_val;
  logic        iss_valid, iss_rd_en;
  logic [4:0]  iss_rd_addr;
  logic        hazard, pend_full;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [31:0] exp_rd1 = '0;
  logic [31:0] exp_rd2 = '0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_val(rf_wr_val),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_val(rd1_val),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_val(rd2_val),
    .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr),
    .hazard(hazard), .pend_full(pend_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of register contents and in-flight write counts.
  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return '0;
    if (rf_wr_en && int'(rf_wr_addr) == a) return rf_wr_val;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(input logic en, input int a);
    return en && a != 0 && m_pend[a] > 0 &&
           !(rf_wr_en && int'(rf_wr_addr) == a && m_pend[a] == 1);
  endfunction

  function automatic logic m_full();
    int a = int'(iss_rd_addr);
    return iss_rd_en && a != 0 && m_pend[a] == 3 && !(rf_wr_en && int'(rf_wr_addr) == a);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      exp_rd1 = '0;
      exp_rd2 = '0;
    end else begin
      if (rd1_en) exp_rd1 = m_read(int'(rd1_addr));
      if (rd2_en) exp_rd2 = m_read(int'(rd2_addr));
      if (rf_wr_en && rf_wr_addr != 0) begin
        m_regs[rf_wr_addr] = rf_wr_val;
        m_pend[rf_wr_addr]--;
      end
      if (iss_valid && iss_rd_en && iss_rd_addr != 0) m_pend[iss_rd_addr]++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1_val", rd1_val, exp_rd1);
      check("rd2_val", rd2_val, exp_rd2);
      check("hazard", 32'(hazard), 32'(m_hazard(rd1_en, int'(rd1_addr)) ||
                                        m_hazard(rd2_en, int'(rd2_addr))));
      check("pend_full", 32'(pend_full), 32'(m_full()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_wr_en = 0; rf_wr_addr = '0; rf_wr_val = '0;
    rd1_en = 0; rd1_addr = '0; rd2_en = 0; rd2_addr = '0;
    iss_valid = 0; iss_rd_en = 0; iss_rd_addr = '0;
  endtask

  task automatic issue(input int a);
    iss_valid = 1; iss_rd_en = 1; iss_rd_addr = 5'(a);
    tick();
    idle();
  endtask

  task automatic writeback(input int a, input logic [31:0] v);
    rf_wr_en = 1; rf_wr_addr = 5'(a); rf_wr_val = v;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // Scenario 1: every register reads zero on both ports after reset.
    for (int i = 1; i < 32; i++) begin
      rd1_en = 1; rd1_addr = 5'(i); rd2_en = 1; rd2_addr = 5'(i);
      #1 check("s1_hazard", 32'(hazard), 32'h0);
      tick();
      check("s1_rd1", rd1_val, 32'h0);
      check("s1_rd2", rd2_val, 32'h0);
    end
    idle();

    // Scenario 2: plain write then read; x0 discards writes.
    issue(5);
    writeback(5, 32'hDEADBEEF);
    rd1_en = 1; rd1_addr = 5'd5;
    tick();
    idle();
    check("s2_rd1_x5", rd1_val, 32'hDEADBEEF);
    writeback(0, 32'h1234);
    rd1_en = 1; rd1_addr = 5'd0;
    tick();
    idle();
    check("s2_rd1_x0", rd1_val, 32'h0);

    // Scenario 3: same-cycle write is forwarded to both ports.
    issue(7);
    rf_wr_en = 1; rf_wr_addr = 5'd7; rf_wr_val = 32'hA5A5A5A5;
    rd1_en = 1; rd1_addr = 5'd7; rd2_en = 1; rd2_addr = 5'd7;
    #1 check("s3_hazard", 32'(hazard), 32'h0);
    tick();
    idle();
    check("s3_rd1", rd1_val, 32'hA5A5A5A5);
    check("s3_rd2", rd2_val, 32'hA5A5A5A5);

    // Scenario 4: pending write stalls the read until its writeback arrives.
    issue(3);
    rd1_en = 1; rd1_addr = 5'd3;
    #1 check("s4_hazard_pending", 32'(hazard), 32'h1);
    tick();
    rf_wr_en = 1; rf_wr_addr = 5'd3; rf_wr_val = 32'h42;
    #1 check("s4_hazard_wb", 32'(hazard), 32'h0);
    tick();
    idle();
    check("s4_rd1", rd1_val, 32'h42);

    // Scenario 5: counter saturation and simultaneous issue+writeback.
    repeat (3) issue(9);
    iss_rd_en = 1; iss_rd_addr = 5'd9;
    #1 check("s5_full_4th", 32'(pend_full), 32'h1);
    iss_valid = 1; rf_wr_en = 1; rf_wr_addr = 5'd9; rf_wr_val = 32'h99;
    #1 check("s5_full_with_wb", 32'(pend_full), 32'h0);
    tick();
    idle();
    iss_rd_en = 1; iss_rd_addr = 5'd9;
    #1 check("s5_still_full", 32'(pend_full), 32'h1);
    idle();
    repeat (3) writeback(9, 32'h77);
    iss_rd_en = 1; iss_rd_addr = 5'd9;
    #1 check("s5_drained", 32'(pend_full), 32'h0);
    idle();

    // Scenario 6: reset mid-flight drops pending bookkeeping.
    issue(4);
    issue(4);
    rst = 1;
    tick();
    rst = 0;
    rd1_en = 1; rd1_addr = 5'd4;
    #1 check("s6_hazard", 32'(hazard), 32'h0);
    tick();
    idle();
    check("s6_rd1", rd1_val, 32'h0);

    // Random traffic, kept within protocol so no counter over/underflows.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 8; t++) begin
          int a = $urandom_range(1, 7);
          if (!rf_wr_en && m_pend[a] > 0) begin
            rf_wr_en = 1; rf_wr_addr = 5'(a);
          end
        end
        if (!rf_wr_en && $urandom_range(0, 3) == 0) rf_wr_en = 1;
        rf_wr_val = $urandom;
      end
      rd1_en = $urandom_range(0, 1); rd1_addr = 5'($urandom_range(0, 7));
      rd2_en = $urandom_range(0, 1); rd2_addr = 5'($urandom_range(0, 9));
      iss_rd_en = ($urandom_range(0, 3) != 0);
      iss_rd_addr = 5'($urandom_range(0, 7));
      iss_valid = $urandom_range(0, 1);
      if (iss_rd_en && iss_rd_addr != 0 && m_pend[iss_rd_addr] == 3 &&
          !(rf_wr_en && rf_wr_addr == iss_rd_addr))
        iss_valid = 0;
      tick();
    end
    idle();
    rst = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
